// File: rtl/vga_object_scheduler.sv
// Double-buffered object table with frame-synchronous commit and a registered priority compositor.
// Optional: define VGA_OBJ_BORDER_EN to draw a white 2-pixel ring around each visible object.
module vga_object_scheduler #(
  parameter int NUM_OBJ  = 8,
  parameter int OBJ_SIZE = 40,
  parameter int COORD_W  = 10
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       frame_start,
  input  logic [COORD_W-1:0]         pixel_X_pos,
  input  logic [COORD_W-1:0]         pixel_Y_pos,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [$clog2(NUM_OBJ)-1:0] cfg_index,
  input  logic [COORD_W-1:0]         cfg_x,
  input  logic [COORD_W-1:0]         cfg_y,
  input  logic [23:0]                cfg_color,
  input  logic                       cfg_enable,
  output logic [7:0]                 VGA_red,
  output logic [7:0]                 VGA_green,
  output logic [7:0]                 VGA_blue,
  output logic                       commit_pulse,
  output logic [7:0]                 commit_count
);

  localparam int IDX_W = $clog2(NUM_OBJ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);
  localparam logic [COORD_W:0] SIZE_EXT = (COORD_W + 1)'(OBJ_SIZE);

  typedef enum logic [1:0] {IDLE, DIRTY, COMMIT} state_t;

  state_t state, state_next;
  logic [IDX_W-1:0] idx;
  logic             xfer;

  logic [COORD_W-1:0] sh_x      [NUM_OBJ];
  logic [COORD_W-1:0] sh_y      [NUM_OBJ];
  logic [23:0]        sh_color  [NUM_OBJ];
  logic [NUM_OBJ-1:0] sh_en;
  logic [COORD_W-1:0] act_x     [NUM_OBJ];
  logic [COORD_W-1:0] act_y     [NUM_OBJ];
  logic [23:0]        act_color [NUM_OBJ];
  logic [NUM_OBJ-1:0] act_en;

  logic [23:0] pix_rgb;
  logic [23:0] rgb_p1;

  // The upper bound is widened one bit so objects near the right/bottom edge clip instead of wrapping.
  function automatic logic in_span(input logic [COORD_W-1:0] pos, input logic [COORD_W-1:0] org);
    logic [COORD_W:0] lim;
    lim = {1'b0, org} + SIZE_EXT;
    return (pos >= org) && ({1'b0, pos} < lim);
  endfunction

`ifdef VGA_OBJ_BORDER_EN
  function automatic logic on_ring(input logic [COORD_W-1:0] pos, input logic [COORD_W-1:0] org);
    logic [COORD_W-1:0] off;
    off = pos - org;
    return (off < COORD_W'(2)) || (off > COORD_W'(OBJ_SIZE - 3));
  endfunction
`endif

  assign xfer = cfg_valid && cfg_ready;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (xfer) state_next = DIRTY;
      DIRTY:   if (frame_start) state_next = COMMIT;
      COMMIT:  if (idx == LAST_IDX) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready    = !reset && (state != COMMIT);
    commit_pulse = (state == COMMIT) && (idx == LAST_IDX);
  end

  // NUM_OBJ is a power of two, so the copy index wraps back to 0 on the last copy.
  always_ff @(posedge clock) begin
    if (reset) begin
      idx          <= '0;
      commit_count <= '0;
    end else begin
      if (state == DIRTY && frame_start) idx <= '0;
      else if (state == COMMIT)          idx <= idx + IDX_W'(1);
      if (commit_pulse) commit_count <= commit_count + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        sh_x[i]     <= '0;
        sh_y[i]     <= '0;
        sh_color[i] <= '0;
      end
      sh_en <= '0;
    end else if (xfer) begin
      sh_x[cfg_index]     <= cfg_x;
      sh_y[cfg_index]     <= cfg_y;
      sh_color[cfg_index] <= cfg_color;
      sh_en[cfg_index]    <= cfg_enable;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        act_x[i]     <= '0;
        act_y[i]     <= '0;
        act_color[i] <= '0;
      end
      act_en <= '0;
    end else if (state == COMMIT) begin
      act_x[idx]     <= sh_x[idx];
      act_y[idx]     <= sh_y[idx];
      act_color[idx] <= sh_color[idx];
      act_en[idx]    <= sh_en[idx];
    end
  end

  // Scanning from the highest index down lets the lowest hit index have the final say.
  always_comb begin
    pix_rgb = '0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (act_en[i] && in_span(pixel_X_pos, act_x[i]) && in_span(pixel_Y_pos, act_y[i])) begin
`ifdef VGA_OBJ_BORDER_EN
        if (on_ring(pixel_X_pos, act_x[i]) || on_ring(pixel_Y_pos, act_y[i])) pix_rgb = 24'hFFFFFF;
        else                                                                  pix_rgb = act_color[i];
`else
        pix_rgb = act_color[i];
`endif
      end
    end
  end

  // Stage p1: registered RGB, one clock after the pixel coordinate
  always_ff @(posedge clock) begin
    if (reset) rgb_p1 <= '0;
    else       rgb_p1 <= pix_rgb;
  end

  assign VGA_red   = rgb_p1[23:16];
  assign VGA_green = rgb_p1[15:8];
  assign VGA_blue  = rgb_p1[7:0];

endmodule
